// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: pulls framed packets (SYNC, LEN, payload, CHK) out of a UART RX
// FIFO, streams payload bytes through a valid/ready port and reports each
// packet's outcome as a one-cycle ok/err pulse.
module uart_pkt_rx #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TOUT_W      = 16,
  parameter int         TIMEOUT_CYC = 52160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic [7:0] pkt_len,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK} state_t;

  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic              pkt_err_q, pkt_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        pkt_len_q, pkt_len_d;

  // Pop whenever a byte is present, except in PAYLOAD while the output slot
  // is full and not being drained this cycle; never pop during reset.
  assign rd_uart = reset && !rx_empty &&
                   ((state_q != S_PAYLOAD) || !out_valid_q || out_ready);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign pkt_len   = pkt_len_q;
  assign busy      = (state_q != S_IDLE);

  // Next-state: packet parsing, output slot, checksum and timeout.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    pkt_len_d   = pkt_len_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // Only starved cycles mid-packet count; backpressure does not.
    if (state_q == S_IDLE || rd_uart) tout_d = '0;
    else if (rx_empty)                tout_d = tout_q + 1'b1;
    else                              tout_d = tout_q;

    case (state_q)
      S_IDLE: begin
        if (rd_uart && r_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (rd_uart) begin
          if (r_data > MAX_LEN_B) begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b10;
            state_d    = S_IDLE;
          end else begin
            len_d   = r_data;
            acc_d   = r_data;
            cnt_d   = '0;
            state_d = (r_data == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rd_uart) begin
          out_data_d  = r_data;
          out_valid_d = 1'b1;
          acc_d       = acc_q ^ r_data;
          cnt_d       = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rd_uart) begin
          if (r_data == acc_q) begin
            pkt_ok_d = 1'b1;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b01;
          end
          pkt_len_d = len_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter is about to reach TIMEOUT_CYC: abort the packet.
    if (state_q != S_IDLE && rx_empty && tout_q == TOUT_LAST) begin
      pkt_err_d  = 1'b1;
      err_code_d = 2'b11;
      state_d    = S_IDLE;
      tout_d     = '0;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tout_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 2'b00;
      pkt_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tout_q      <= tout_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      pkt_len_q   <= pkt_len_d;
    end
  end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: a queue-backed FIFO and consumer drive the DUT;
// expected payload/outcomes come from the packets the bench itself builds.
module tb_uart_pkt_rx;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXL = 16;
  localparam int TOUT = 40;

  logic clk = 1'b0, reset = 1'b0, rx_empty = 1'b1, out_ready = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic rd_uart, out_valid, pkt_ok, pkt_err, busy;
  logic [7:0] out_data, pkt_len;
  logic [1:0] err_code;

  uart_pkt_rx #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TOUT_W(8), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .pkt_len(pkt_len), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {logic ok; logic [1:0] code; logic [7:0] len; int cyc;} ev_t;

  logic [7:0] fifo[$], got[$], exp_pl[$], last_pl[$];
  ev_t evq[$], exp_ev[$];
  int cyc = 0, last_pop_cyc = 0, pops = 0, stall_brk = 0, both_hi = 0, bad_pop = 0;
  int n_chk = 0, n_fail = 0;
  int ready_mode = 1, gap_pct = 0;

  // One clock: drive inputs after negedge, observe handshakes, pop FIFO.
  task automatic cycle();
    logic pop, stall;
    logic [7:0] d0;
    rx_empty  = (fifo.size() == 0) || ($urandom_range(99) < gap_pct);
    r_data    = rx_empty ? 8'($urandom) : fifo[0];
    out_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : 1'($urandom_range(1));
    #1;
    pop = rd_uart; stall = out_valid && !out_ready; d0 = out_data;
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    cyc++;
    if (pop) begin
      if (rx_empty) bad_pop++;
      else begin void'(fifo.pop_front()); pops++; last_pop_cyc = cyc; end
    end
    @(negedge clk);
    if (stall && (out_data !== d0 || out_valid !== 1'b1)) stall_brk++;
    if (pkt_ok && pkt_err) both_hi++;
    if (pkt_ok || pkt_err) evq.push_back('{pkt_ok, err_code, pkt_len, cyc});
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((fifo.size() > 0 || out_valid || busy) && n < bound) begin cycle(); n++; end
    repeat (2) cycle();
    n_chk++;
    if (n >= bound) begin n_fail++; $display("FAIL drain_bound: still busy after %0d cycles", n); end
  endtask

  task automatic clear();
    got.delete(); evq.delete(); exp_pl.delete(); exp_ev.delete();
    pops = 0; stall_brk = 0;
  endtask

  // Builds a packet of random payload; chk is XOR of LEN and payload.
  task automatic push_pkt(input int len, input bit corrupt);
    logic [7:0] chk, b;
    chk = 8'(len);
    fifo.push_back(SYNC); fifo.push_back(8'(len));
    last_pl.delete();
    for (int i = 0; i < len; i++) begin
      b = ($urandom_range(7) == 0) ? SYNC : 8'($urandom);
      chk ^= b; fifo.push_back(b); last_pl.push_back(b); exp_pl.push_back(b);
    end
    if (corrupt) chk ^= 8'($urandom_range(1, 255));
    fifo.push_back(chk);
  endtask

  task automatic test_reset();
    reset = 1'b0; fifo = '{SYNC}; gap_pct = 0; ready_mode = 1;
    cycle(); cycle();
    n_chk++; if (rd_uart !== 1'b0 || pops != 0) begin n_fail++; $display("FAIL reset_rd_uart: rd=%b pops=%0d want 0", rd_uart, pops); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: %b want 0", out_valid); end
    n_chk++; if (pkt_ok !== 1'b0 || pkt_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: ok=%b err=%b want 0", pkt_ok, pkt_err); end
    n_chk++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: %b want 00", err_code); end
    n_chk++; if (pkt_len !== 8'h00 || out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: len=%h data=%h want 00", pkt_len, out_data); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b want 0", busy); end
    fifo.delete(); reset = 1'b1; cycle();
  endtask

  task automatic test_good();
    clear(); ready_mode = 1; gap_pct = 0;
    fifo = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    drain(100);
    n_chk++; if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      n_fail++; $display("FAIL good_payload: %0d bytes got, want 11 22 33", got.size()); end
    n_chk++; if (evq.size() != 1 || evq[0].ok !== 1'b1 || evq[0].len !== 8'd3) begin
      n_fail++; $display("FAIL good_event: %0d events, want one pkt_ok len 3", evq.size()); end
    n_chk++; if (evq.size() != 1 || evq[0].cyc != last_pop_cyc) begin
      n_fail++; $display("FAIL good_ok_timing: event not one cycle after CHK byte"); end
    n_chk++; if (busy !== 1'b0 || pkt_len !== 8'd3) begin n_fail++; $display("FAIL good_after: busy=%b len=%0d want 0/3", busy, pkt_len); end
  endtask

  task automatic test_bad_chk();
    clear(); ready_mode = 1; gap_pct = 0;
    fifo = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    drain(100);
    n_chk++; if (got.size() != 3) begin n_fail++; $display("FAIL badchk_payload: %0d bytes, want 3", got.size()); end
    n_chk++; if (evq.size() != 1 || evq[0].ok !== 1'b0 || evq[0].code !== 2'b01 || evq[0].len !== 8'd3) begin
      n_fail++; $display("FAIL badchk_event: %0d events code=%b, want one err 01 len 3", evq.size(), err_code); end
  endtask

  task automatic test_discard_zero();
    clear(); ready_mode = 1; gap_pct = 0;
    fifo = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    drain(100);
    n_chk++; if (got.size() != 0) begin n_fail++; $display("FAIL zero_payload: %0d bytes, want 0", got.size()); end
    n_chk++; if (evq.size() != 1 || evq[0].ok !== 1'b1 || evq[0].len !== 8'd0) begin
      n_fail++; $display("FAIL zero_event: %0d events, want one pkt_ok len 0", evq.size()); end
  endtask

  task automatic test_bad_len();
    clear(); ready_mode = 1; gap_pct = 0;
    fifo = '{8'hA5, 8'h11};
    drain(100);
    n_chk++; if (evq.size() != 1 || evq[0].ok !== 1'b0 || evq[0].code !== 2'b10) begin
      n_fail++; $display("FAIL badlen_event: %0d events code=%b, want one err 10", evq.size(), err_code); end
    n_chk++; if (evq.size() != 1 || evq[0].cyc != last_pop_cyc || busy !== 1'b0) begin
      n_fail++; $display("FAIL badlen_timing: busy=%b, want err one cycle after LEN and idle", busy); end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear(); ready_mode = 1; gap_pct = 0;
    push_pkt(5, 1'b0); drain(100);
    clear();
    fifo = '{8'hA5, 8'h02, 8'hAA};
    while (evq.size() == 0 && n < TOUT + 20) begin cycle(); n++; end
    n_chk++; if (evq.size() != 1 || evq[0].ok !== 1'b0 || evq[0].code !== 2'b11) begin
      n_fail++; $display("FAIL timeout_event: %0d events code=%b, want one err 11", evq.size(), err_code); end
    n_chk++; if (evq.size() != 1 || evq[0].cyc - last_pop_cyc != TOUT) begin
      n_fail++; $display("FAIL timeout_delay: fired after %0d idle cycles, want %0d", (evq.size() > 0) ? evq[0].cyc - last_pop_cyc : -1, TOUT); end
    n_chk++; if (pkt_len !== 8'd5) begin n_fail++; $display("FAIL timeout_pkt_len: %0d want 5", pkt_len); end
    n_chk++; if (got.size() != 1 || got[0] !== 8'hAA || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_payload: %0d bytes busy=%b, want AA and idle", got.size(), busy); end
  endtask

  task automatic test_backpressure();
    clear(); ready_mode = 2; gap_pct = 0;
    push_pkt(4, 1'b0);
    repeat (60) cycle();
    n_chk++; if (pops != 3) begin n_fail++; $display("FAIL bp_pops: %0d bytes consumed under stall, want 3", pops); end
    n_chk++; if (stall_brk != 0) begin n_fail++; $display("FAIL bp_stable: out_data changed %0d times, want 0", stall_brk); end
    n_chk++; if (evq.size() != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_no_timeout: %0d events busy=%b", evq.size(), busy); end
    n_chk++; if (out_valid !== 1'b1 || out_data !== last_pl[0]) begin
      n_fail++; $display("FAIL bp_held: valid=%b data=%h want 1/%h", out_valid, out_data, last_pl[0]); end
    ready_mode = 1; drain(100);
    n_chk++; if (got != exp_pl) begin n_fail++; $display("FAIL bp_payload: %0d bytes, want %0d", got.size(), exp_pl.size()); end
    n_chk++; if (evq.size() != 1 || evq[0].ok !== 1'b1 || evq[0].len !== 8'd4) begin
      n_fail++; $display("FAIL bp_event: %0d events, want one pkt_ok len 4", evq.size()); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    clear(); ready_mode = 1; gap_pct = 0;
    push_pkt(4, 1'b0);
    while (pops < 4 && n < 20) begin cycle(); n++; end
    reset = 1'b0; cycle(); reset = 1'b1;
    n_chk++; if (pops != 4) begin n_fail++; $display("FAIL midrst_pops: %0d, want 4 (no pop in reset)", pops); end
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: valid=%b busy=%b want 0/0", out_valid, busy); end
    fifo.delete(); clear();
    push_pkt(3, 1'b0); drain(100);
    n_chk++; if (got != exp_pl || evq.size() != 1 || evq[0].ok !== 1'b1 || evq[0].len !== 8'd3) begin
      n_fail++; $display("FAIL midrst_next_pkt: %0d bytes %0d events, want 3 bytes and pkt_ok", got.size(), evq.size()); end
  endtask

  task automatic test_random();
    int kind, len, bad_b, bad_e;
    logic [7:0] plen, g;
    clear(); ready_mode = 0; gap_pct = 15;
    plen = 8'd0;
    for (int p = 0; p < 40; p++) begin
      for (int k = $urandom_range(2); k > 0; k--) begin
        do g = 8'($urandom); while (g == SYNC);
        fifo.push_back(g);
      end
      kind = (p == 0) ? 9 : $urandom_range(9);
      if (kind == 0) begin
        fifo.push_back(SYNC); fifo.push_back(8'($urandom_range(MAXL + 1, 255)));
        exp_ev.push_back('{1'b0, 2'b10, plen, 0});
      end else begin
        len = $urandom_range(MAXL);
        push_pkt(len, kind <= 2);
        plen = 8'(len);
        exp_ev.push_back('{kind > 2, (kind <= 2) ? 2'b01 : 2'b00, plen, 0});
      end
    end
    drain(8000);
    bad_b = 0;
    for (int i = 0; i < got.size() && i < exp_pl.size(); i++) if (got[i] !== exp_pl[i]) bad_b++;
    n_chk++; if (got.size() != exp_pl.size() || bad_b != 0) begin
      n_fail++; $display("FAIL rand_payload: %0d bytes (%0d wrong), want %0d", got.size(), bad_b, exp_pl.size()); end
    bad_e = 0;
    for (int i = 0; i < evq.size() && i < exp_ev.size(); i++)
      if (evq[i].ok !== exp_ev[i].ok || evq[i].len !== exp_ev[i].len ||
          (!exp_ev[i].ok && evq[i].code !== exp_ev[i].code)) bad_e++;
    n_chk++; if (evq.size() != exp_ev.size() || bad_e != 0) begin
      n_fail++; $display("FAIL rand_events: %0d events (%0d wrong), want %0d", evq.size(), bad_e, exp_ev.size()); end
    n_chk++; if (both_hi != 0 || bad_pop != 0 || stall_brk != 0) begin
      n_fail++; $display("FAIL rand_protocol: both_hi=%0d bad_pop=%0d stall_brk=%0d want 0", both_hi, bad_pop, stall_brk); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good();
    test_bad_chk();
    test_discard_zero();
    test_bad_len();
    test_timeout();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_pkt_rx.md
UART_PKT_RX -- requirements
Module: uart_pkt_rx

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-002 Parameter MAX_LEN, default 16, largest legal payload length in bytes.
REQ-003 Parameter TOUT_W, default 16, width of the inter-byte timeout counter.
REQ-004 Parameter TIMEOUT_CYC, default 52160, idle clk cycles allowed mid-packet (two byte times at 19,200 baud, 50 MHz).
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 rx_empty  input  1  UART RX FIFO empty flag.
REQ-008 r_data  input  8  UART RX FIFO head byte, valid while rx_empty=0.
REQ-009 rd_uart  output  1  FIFO pop strobe; the byte on r_data is consumed at the edge where rd_uart=1.
REQ-010 out_data  output  8  payload byte.
REQ-011 out_valid  output  1  out_data holds an undelivered payload byte.
REQ-012 out_ready  input  1  consumer accepts out_data at the edge where out_valid=out_ready=1.
REQ-013 pkt_ok  output  1  one-cycle pulse: packet ended with a good checksum.
REQ-014 pkt_err  output  1  one-cycle pulse: packet aborted.
REQ-015 err_code  output  2  01 checksum, 10 length, 11 timeout; holds until the next pkt_err.
REQ-016 pkt_len  output  8  length field of the last completed or checksum-failed packet.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 Packet format: SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK SHALL equal XOR of LEN and all payload bytes.
REQ-019 FSM states IDLE, LEN, PAYLOAD, CHK; one byte is consumed per cycle at most.
REQ-020 rd_uart SHALL be combinational: !rx_empty && (state!=PAYLOAD || !out_valid || out_ready).
REQ-021 IDLE: consumed byte == SYNC_BYTE -> LEN; any other byte is discarded silently, with no error.
REQ-022 LEN: byte L > MAX_LEN -> pkt_err, err_code=10, IDLE; L==0 -> CHK; else -> PAYLOAD; checksum accumulator loads L; byte counter clears.
REQ-023 PAYLOAD: each consumed byte loads out_data and sets out_valid next cycle; accumulator ^= byte; counter++; -> CHK after the L-th byte.
REQ-024 out_valid clears on handshake unless a new byte loads in the same cycle, in which case it stays 1 with the new out_data.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL stay stable and rd_uart SHALL be 0 in PAYLOAD; no byte is lost.
REQ-026 CHK: byte == accumulator -> pkt_ok; else pkt_err with err_code=01; pkt_len<=L in both cases; -> IDLE.
REQ-027 pkt_ok and pkt_err are registered, asserted the cycle after the deciding byte is consumed, and never high together.
REQ-028 Timeout counter: cleared in IDLE and on every consumed byte; increments only on cycles in LEN/PAYLOAD/CHK with rx_empty=1.
REQ-029 When the timeout counter reaches TIMEOUT_CYC: pkt_err, err_code=11, -> IDLE; pkt_len is unchanged.
REQ-030 Backpressure cycles (rx_empty=0, out_ready=0) SHALL NOT advance the timeout counter.
REQ-031 Payload bytes already emitted are not retracted on error; the consumer qualifies them by pkt_ok or pkt_err.
REQ-032 A SYNC_BYTE value inside LEN, PAYLOAD or CHK is treated as data, not as a resync.

Reset
REQ-033 On reset=0 at a clock edge, the block SHALL enter IDLE with out_valid=0, pkt_ok=0, pkt_err=0, err_code=00, pkt_len=0, out_data=0, busy=0, and counters and accumulator at 0.
REQ-034 A mid-packet reset SHALL drop the partial packet and any pending out_data; rd_uart is 0 while reset=0.

Verification
REQ-035 FIFO bytes A5 03 11 22 33 03, out_ready=1 -> out_data 11, 22, 33; then pkt_ok pulse, pkt_len=3, busy=0.
REQ-036 FIFO bytes A5 03 11 22 33 04 -> three payload bytes, then pkt_err with err_code=01 and pkt_len=3.
REQ-037 FIFO bytes 00 FF A5 00 00 -> the first two bytes are discarded, no out_valid, then pkt_ok with pkt_len=0.
REQ-038 FIFO bytes A5 11 (L=17) -> pkt_err with err_code=10 one cycle after the LEN byte, back in IDLE.
REQ-039 FIFO bytes A5 02 AA, then rx_empty=1 for TIMEOUT_CYC cycles -> pkt_err with err_code=11; pkt_len keeps its prior value.
REQ-040 Good packet with out_ready=0 for 50 cycles during payload -> rd_uart=0 and out_data stable throughout, no timeout, all bytes delivered, then pkt_ok.
REQ-041 reset=0 for one cycle after the second payload byte -> IDLE, out_valid=0; a following good packet is received correctly.
